// File: rtl/spi_slave_xcvr.sv
// Full-duplex SPI slave with all four CPOL/CPHA modes, configurable word width
// and bit order, oversampled by clk, with valid/ready TX and RX system ports.
module spi_slave_xcvr #(
  parameter int unsigned       DATA_W    = 8,
  parameter bit                CPOL      = 1'b0,
  parameter bit                CPHA      = 1'b0,
  parameter bit                MSB_FIRST = 1'b1,
  parameter logic [DATA_W-1:0] IDLE_TX   = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sclk,
  input  logic                      cs,
  input  logic                      mosi,
  output logic                      miso,
  output logic                      miso_oe,
  input  logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  output logic [DATA_W-1:0]         rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      rx_overrun,
  output logic                      tx_underrun,
  output logic                      busy,
  output logic [$clog2(DATA_W)-1:0] test_bit_count
);

  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        sclk_sync_q, sclk_sync_d;
  logic [1:0]        cs_sync_q, cs_sync_d;
  logic [1:0]        mosi_sync_q, mosi_sync_d;
  logic              sclk_prev_q, sclk_prev_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              load_pend_q, load_pend_d;
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              rx_overrun_q, rx_overrun_d;
  logic              tx_underrun_q, tx_underrun_d;

  logic              sclk_s, cs_s, mosi_s;
  logic              lead_edge, trail_edge, sample_edge, shift_edge;
  logic              load, shift, word_done;
  logic [DATA_W-1:0] rx_word;

  assign sclk_s = sclk_sync_q[1];
  assign cs_s   = cs_sync_q[1];
  assign mosi_s = mosi_sync_q[1];

  assign lead_edge   = (sclk_prev_q == CPOL) && (sclk_s != CPOL);
  assign trail_edge  = (sclk_prev_q != CPOL) && (sclk_s == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge  : trail_edge;

  always_comb begin
    sclk_sync_d   = {sclk_sync_q[0], sclk};
    cs_sync_d     = {cs_sync_q[0], cs};
    mosi_sync_d   = {mosi_sync_q[0], mosi};
    sclk_prev_d   = sclk_s;
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    load_pend_d   = load_pend_q;
    hold_full_d   = hold_full_q;
    hold_d        = hold_q;
    tx_sh_d       = tx_sh_q;
    rx_sh_d       = rx_sh_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    rx_overrun_d  = 1'b0;
    tx_underrun_d = 1'b0;
    load          = 1'b0;
    shift         = 1'b0;
    word_done     = 1'b0;
    rx_word       = MSB_FIRST ? {rx_sh_q[DATA_W-2:0], mosi_s}
                              : {mosi_s, rx_sh_q[DATA_W-1:1]};

    case (state_q)
      S_IDLE: begin
        if (!cs_s) begin
          state_d = S_ACTIVE;
          load    = !CPHA;
        end
      end
      default: begin
        if (cs_s) begin
          // Deselect drops the partial word; the loaded TX word is already spent.
          state_d     = S_IDLE;
          bit_cnt_d   = '0;
          load_pend_d = 1'b0;
        end else begin
          if (sample_edge) begin
            rx_sh_d = rx_word;
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_d   = '0;
              word_done   = 1'b1;
              load_pend_d = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + CW'(1);
            end
          end
          if (shift_edge) begin
            if (CPHA ? (bit_cnt_q == '0) : load_pend_q) begin
              load        = 1'b1;
              load_pend_d = 1'b0;
            end else begin
              shift = 1'b1;
            end
          end
        end
      end
    endcase

    if (load) begin
      if (hold_full_q) begin
        tx_sh_d = hold_q;
      end else begin
        tx_sh_d       = IDLE_TX;
        tx_underrun_d = 1'b1;
      end
      hold_full_d = 1'b0;
    end else if (shift) begin
      tx_sh_d = MSB_FIRST ? {tx_sh_q[DATA_W-2:0], 1'b0} : {1'b0, tx_sh_q[DATA_W-1:1]};
    end

    // Capture is judged against the pre-cycle state, so a same-cycle load wins.
    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    if (word_done) begin
      rx_data_d  = rx_word;
      rx_valid_d = 1'b1;
      if (rx_valid_q && !rx_ready) rx_overrun_d = 1'b1;
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q   <= {CPOL, CPOL};
      cs_sync_q     <= 2'b11;
      mosi_sync_q   <= 2'b00;
      sclk_prev_q   <= CPOL;
      state_q       <= S_IDLE;
      bit_cnt_q     <= '0;
      load_pend_q   <= 1'b0;
      hold_full_q   <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      sclk_sync_q   <= sclk_sync_d;
      cs_sync_q     <= cs_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      sclk_prev_q   <= sclk_prev_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      load_pend_q   <= load_pend_d;
      hold_full_q   <= hold_full_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      rx_overrun_q  <= rx_overrun_d;
      tx_underrun_q <= tx_underrun_d;
    end
  end

  always_ff @(posedge clk) begin
    hold_q  <= hold_d;
    tx_sh_q <= tx_sh_d;
    rx_sh_q <= rx_sh_d;
  end

  assign busy           = (state_q == S_ACTIVE);
  assign miso_oe        = busy;
  assign miso           = busy & (MSB_FIRST ? tx_sh_q[DATA_W-1] : tx_sh_q[0]);
  assign tx_ready       = !hold_full_q;
  assign rx_data        = rx_data_q;
  assign rx_valid       = rx_valid_q;
  assign rx_overrun     = rx_overrun_q;
  assign tx_underrun    = tx_underrun_q;
  assign test_bit_count = bit_cnt_q;

endmodule

// File: tb/tb_spi_slave_xcvr.sv
// Bench for spi_slave_xcvr: four configurations (mode 0 8-bit MSB-first, modes 1-3
// 16-bit LSB-first) driven by a bit-level SPI master against a word-level model.
module tb_spi_slave_xcvr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : cfg
    localparam int DW = (g == 0) ? 8 : 16;
    localparam int CW = $clog2(DW);
    localparam bit POL = (g >= 2);
    localparam bit PHA = (g % 2 == 1);
    localparam bit MSBF = (g == 0);
    localparam logic [31:0] ITX32 = (g == 0) ? 32'hFF : 32'hA5C3;
    localparam logic [DW-1:0] ITX = ITX32[DW-1:0];

    logic rst = 1'b1, sclk = POL, cs = 1'b1, mosi = 1'b0;
    logic miso, miso_oe, tx_ready, rx_valid, rx_overrun, tx_underrun, busy;
    logic tx_valid = 1'b0, rx_ready = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic [DW-1:0] rx_data;
    logic [CW-1:0] bcnt;

    spi_slave_xcvr #(.DATA_W(DW), .CPOL(POL), .CPHA(PHA), .MSB_FIRST(MSBF), .IDLE_TX(ITX)) u_dut (
      .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
      .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .rx_overrun(rx_overrun), .tx_underrun(tx_underrun), .busy(busy),
      .test_bit_count(bcnt)
    );

    // Word-level model: expected RX words, expected MISO words per load event,
    // holding-register occupancy and expected flag counts.
    logic [31:0] rx_exp[$];
    logic [31:0] tx_exp[$];
    bit          held_full = 1'b0;
    logic [31:0] held_val = '0;
    int exp_ovr = 0, exp_und = 0, got_ovr = 0, got_und = 0;
    bit hold_rdy = 1'b0;

    always @(negedge clk) begin
      logic rdy;
      if (rx_overrun) got_ovr++;
      if (tx_underrun) got_und++;
      rdy = !hold_rdy && ($urandom_range(3) != 0);
      rx_ready = rdy;
      if (rx_valid && rdy && !rst) begin
        if (rx_exp.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL c%0d_rx_unexpected: got 0x%0h, expected no word", g, rx_data);
        end else begin
          chk($sformatf("c%0d_rx_data", g), 32'(rx_data), rx_exp.pop_front());
        end
      end
    end

    task automatic half();
      repeat (5) @(negedge clk);
    endtask

    task automatic do_load();
      if (held_full) begin
        tx_exp.push_back(held_val);
        held_full = 1'b0;
      end else begin
        tx_exp.push_back(32'(ITX));
        exp_und++;
      end
    endtask

    task automatic queue_tx();
      logic [DW-1:0] v;
      chk($sformatf("c%0d_tx_ready", g), 32'(tx_ready), 32'(!held_full));
      if (held_full) return;
      v = DW'($urandom);
      tx_data = v;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      held_full = 1'b1;
      held_val = 32'(v);
    endtask

    task automatic drain();
      for (int t = 0; t < 400 && (rx_exp.size() != 0 || rx_valid); t++) @(negedge clk);
      chk($sformatf("c%0d_rx_drain", g), 32'(rx_exp.size()), 32'd0);
    endtask

    task automatic pop_tx(input bit compare, input logic [DW-1:0] got);
      if (tx_exp.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL c%0d_miso_model: got 0x%0h, expected a loaded word", g, got);
      end else if (compare) begin
        chk($sformatf("c%0d_miso_word", g), 32'(got), tx_exp.pop_front());
      end else begin
        void'(tx_exp.pop_front());
      end
    endtask

    task automatic xfer_word(input logic [DW-1:0] w, input int nbits, input bit push_rx,
                             input bit q_next);
      logic [DW-1:0] got;
      got = '0;
      for (int i = 0; i < nbits; i++) begin
        int idx;
        idx = MSBF ? DW - 1 - i : i;
        if (!PHA) begin
          mosi = w[idx];
          half();
          if (i == DW - 1 && push_rx) rx_exp.push_back(32'(w));
          got[idx] = miso;
          sclk = ~POL;
          half();
          sclk = POL;
          if (i == DW - 1) do_load();
        end else begin
          half();
          if (i == 0) do_load();
          sclk = ~POL;
          mosi = w[idx];
          half();
          if (i == DW - 1 && push_rx) rx_exp.push_back(32'(w));
          got[idx] = miso;
          sclk = POL;
        end
        if (i == DW / 2 && q_next) queue_tx();
      end
      if (nbits == DW) pop_tx(1'b1, got);
    endtask

    task automatic burst(input int nw, input bit hold, input bit noq);
      if (hold) begin
        drain();
        hold_rdy = 1'b1;
      end
      if (!noq && $urandom_range(1) == 1) queue_tx();
      cs = 1'b0;
      if (!PHA) do_load();
      repeat (8) @(negedge clk);
      for (int k = 0; k < nw; k++) begin
        logic [DW-1:0] w;
        w = DW'($urandom);
        xfer_word(w, DW, !hold || k == nw - 1, !noq && $urandom_range(1) == 1);
        if (hold && k > 0) exp_ovr++;
      end
      half();
      cs = 1'b1;
      if (!PHA) pop_tx(1'b0, '0);
      repeat (6) @(negedge clk);
      chk($sformatf("c%0d_busy_after_cs", g), 32'(busy), 32'd0);
      if (hold) begin
        chk($sformatf("c%0d_rx_valid_held", g), 32'(rx_valid), 32'd1);
        hold_rdy = 1'b0;
      end
    endtask

    task automatic partial(input int nb);
      logic [DW-1:0] w;
      w = DW'($urandom);
      cs = 1'b0;
      if (!PHA) do_load();
      repeat (8) @(negedge clk);
      xfer_word(w, nb, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      chk($sformatf("c%0d_cnt_mid", g), 32'(bcnt), 32'(nb));
      cs = 1'b1;
      pop_tx(1'b0, '0);
      repeat (5) @(negedge clk);
      chk($sformatf("c%0d_cnt_cs_up", g), 32'(bcnt), 32'd0);
    endtask

    task automatic rst_mid();
      logic [DW-1:0] w;
      drain();
      w = DW'($urandom);
      cs = 1'b0;
      if (!PHA) do_load();
      repeat (8) @(negedge clk);
      xfer_word(w, 5, 1'b0, 1'b0);
      queue_tx();
      chk($sformatf("c%0d_tx_ready_full", g), 32'(tx_ready), 32'd0);
      sclk = ~POL;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      held_full = 1'b0;
      tx_exp.delete();
      chk($sformatf("c%0d_rst_busy", g), 32'(busy), 32'd0);
      chk($sformatf("c%0d_rst_oe", g), 32'(miso_oe), 32'd0);
      chk($sformatf("c%0d_rst_rxv", g), 32'(rx_valid), 32'd0);
      chk($sformatf("c%0d_rst_txr", g), 32'(tx_ready), 32'd1);
      chk($sformatf("c%0d_rst_cnt", g), 32'(bcnt), 32'd0);
      cs = 1'b1;
      for (int i = 0; i < 3; i++) begin
        sclk = POL;
        half();
        sclk = ~POL;
        half();
      end
      sclk = POL;
      repeat (4) @(negedge clk);
      chk($sformatf("c%0d_ign_cnt", g), 32'(bcnt), 32'd0);
      chk($sformatf("c%0d_ign_busy", g), 32'(busy), 32'd0);
      chk($sformatf("c%0d_ign_rxv", g), 32'(rx_valid), 32'd0);
    endtask

    initial begin
      repeat (3) @(negedge clk);
      chk($sformatf("c%0d_r_busy", g), 32'(busy), 32'd0);
      chk($sformatf("c%0d_r_oe", g), 32'(miso_oe), 32'd0);
      chk($sformatf("c%0d_r_miso", g), 32'(miso), 32'd0);
      chk($sformatf("c%0d_r_txr", g), 32'(tx_ready), 32'd1);
      chk($sformatf("c%0d_r_rxv", g), 32'(rx_valid), 32'd0);
      chk($sformatf("c%0d_r_rxd", g), 32'(rx_data), 32'd0);
      chk($sformatf("c%0d_r_cnt", g), 32'(bcnt), 32'd0);
      chk($sformatf("c%0d_r_flags", g), 32'({rx_overrun, tx_underrun}), 32'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      for (int r = 0; r < 5; r++) burst($urandom_range(3, 1), 1'b0, 1'b0);
      burst(3, 1'b1, 1'b0);
      partial(5);
      burst(1, 1'b0, 1'b0);
      burst(2, 1'b0, 1'b1);
      rst_mid();
      burst(2, 1'b0, 1'b0);
      drain();
      repeat (10) @(negedge clk);
      chk($sformatf("c%0d_overruns", g), 32'(got_ovr), 32'(exp_ovr));
      chk($sformatf("c%0d_underruns", g), 32'(got_und), 32'(exp_und));
      chk($sformatf("c%0d_tx_model_left", g), 32'(tx_exp.size()), 32'd0);
      done_cnt++;
    end
  end

  initial begin
    fork
      wait (done_cnt == 4);
      #600us;
    join_any
    if (done_cnt != 4) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: got %0d configurations done, expected 4", done_cnt);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
